// File: rtl/prml_pkg.sv
// rtl/prml_pkg.sv - shared types, reset constant and encoding function for the PRML trellis coder
//
// Purpose: common definitions for the encoder and for any model that has to
//          match it bit for bit. The decoder bench reuses these as well.
// Contents:
//   prml_sym_t      two-bit code symbol {first, second}
//   PRML_STATE_RST  trellis state {p1, p2} after reset
//   prml_phase_t    serialiser phase (slot start / second bit)
//   prml_encode     {c1, c2} from data bit and previous symbol
package prml_pkg;

  typedef logic [1:0] prml_sym_t;

  localparam prml_sym_t PRML_STATE_RST = 2'b00;

  typedef enum logic {
    PH_SECOND = 1'b0,
    PH_START  = 1'b1
  } prml_phase_t;

  // c1 folds in the previous second bit; c2 then folds in the previous first
  // bit, so c2 ^ c1 always reproduces the previous first bit.
  function automatic prml_sym_t prml_encode(input logic d, input logic p1, input logic p2);
    logic c1;
    c1 = d ^ p2;
    return {c1, c1 ^ p1};
  endfunction

endpackage

// File: rtl/prml_encoder_if.sv
// rtl/prml_encoder_if.sv - data-bit handshake into the PRML encoder
//
// Purpose: bundles the per-slot input handshake.
// Signals:
//   data_in     data bit to encode
//   data_valid  data_in is valid
//   data_ready  encoder accepts data_in on this edge
//   inject_err  invert the second coded bit of this slot's symbol
// Modports: master = data source, slave = encoder.
interface prml_encoder_if;
  logic data_in;
  logic data_valid;
  logic data_ready;
  logic inject_err;

  modport master (
    output data_in,
    output data_valid,
    output inject_err,
    input  data_ready
  );

  modport slave (
    input  data_in,
    input  data_valid,
    input  inject_err,
    output data_ready
  );
endinterface

// File: rtl/prml_precoder.sv
// rtl/prml_precoder.sv - trellis state and combinational encoding for the PRML coder
//
// Purpose: holds the previous symbol (p1, p2) and presents the code bits for
//          the current data bit.
// Ports:
//   clock, reset  bit clock, asynchronous active-low reset
//   d             data bit for the current slot (0 when idle)
//   advance       slot start: p1 takes c1
//   commit        second edge: p2 takes p2_in
//   p2_in         uninjected second bit being committed
//   c1, c2        code bits for d against the current trellis state
module prml_precoder
  import prml_pkg::*;
(
  input  logic clock,
  input  logic reset,
  input  logic d,
  input  logic advance,
  input  logic commit,
  input  logic p2_in,
  output logic c1,
  output logic c2
);

  logic p1;
  logic p2;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      p1 <= PRML_STATE_RST[1];
      p2 <= PRML_STATE_RST[0];
    end else begin
      if (advance) p1 <= c1;
      if (commit)  p2 <= p2_in;
    end
  end

  always_comb begin
    {c1, c2} = prml_encode(d, p1, p2);
  end

endmodule

// File: rtl/prml_encoder.sv
// rtl/prml_encoder.sv - serial rate-1/2 PRML trellis encoder with idle fill and error injection
//
// Purpose: takes one data bit per two-clock slot and emits its two code bits
//          serially, first bit then second bit.
// Ports:
//   clock, reset  bit clock, asynchronous active-low reset
//   link          data handshake (slave side)
//   out           registered serial code bit
//   out_phase     0: out is the first bit, 1: out is the second bit
//   idle          symbol on out is filler
//   err_flag      bit on out was inverted by injection
//   sym_count     data symbols accepted, wraps
module prml_encoder
  import prml_pkg::*;
#(
  parameter int CNT_W = 16
) (
  input  logic             clock,
  input  logic             reset,
  prml_encoder_if.slave    link,
  output logic             out,
  output logic             out_phase,
  output logic             idle,
  output logic             err_flag,
  output logic [CNT_W-1:0] sym_count
);

  prml_phase_t phase;
  prml_phase_t phase_next;
  logic        slot_start;
  logic        accept;
  logic        d;
  logic        c1;
  logic        c2;
  logic        c2_hold;
  logic        inj_hold;

  // Phase FSM: state register.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) phase <= PH_START;
    else        phase <= phase_next;
  end

  // Phase FSM: next state. Every slot is exactly two clocks, data or idle.
  always_comb begin
    phase_next = PH_START;
    case (phase)
      PH_START:  phase_next = PH_SECOND;
      PH_SECOND: phase_next = PH_START;
      default:   phase_next = PH_START;
    endcase
  end

  // Phase FSM: outputs.
  always_comb begin
    slot_start = (phase == PH_START);
    accept     = slot_start & link.data_valid;
    out_phase  = (phase == PH_START);
  end

  assign link.data_ready = (phase == PH_START);

  // Idle slots encode a 0 so the trellis keeps advancing.
  assign d = link.data_valid & link.data_in;

  prml_precoder u_precoder (
    .clock   (clock),
    .reset   (reset),
    .d       (d),
    .advance (slot_start),
    .commit  (!slot_start),
    .p2_in   (c2_hold),
    .c1      (c1),
    .c2      (c2)
  );

  // Injection touches only the line bit; p2 is committed from c2_hold.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      out       <= 1'b0;
      idle      <= 1'b1;
      err_flag  <= 1'b0;
      c2_hold   <= 1'b0;
      inj_hold  <= 1'b0;
      sym_count <= '0;
    end else if (slot_start) begin
      out      <= c1;
      c2_hold  <= c2;
      inj_hold <= link.inject_err;
      err_flag <= 1'b0;
      idle     <= !link.data_valid;
      if (accept) sym_count <= sym_count + 1'b1;
    end else begin
      out      <= c2_hold ^ inj_hold;
      err_flag <= inj_hold;
    end
  end

endmodule

// File: tb/tb_prml_encoder.sv
// tb/tb_prml_encoder.sv - self-checking bench for prml_encoder
module tb_prml_encoder;

  logic       clock;
  logic       reset;
  logic       out;
  logic       out_phase;
  logic       idle;
  logic       err_flag;
  logic [3:0] sym_count;

  int n_total = 0;
  int n_pass  = 0;

  prml_encoder_if bus ();

  prml_encoder #(.CNT_W(4)) dut (
    .clock     (clock),
    .reset     (reset),
    .link      (bus.slave),
    .out       (out),
    .out_phase (out_phase),
    .idle      (idle),
    .err_flag  (err_flag),
    .sym_count (sym_count)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  typedef struct {
    bit         rst;
    bit         d;
    bit         v;
    bit         inj;
    bit         e1;
    bit         e2;
    bit         eidle;
    bit         eerr;
    logic [3:0] ecnt;
  } vec_t;

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  task automatic do_reset();
    reset = 1'b0;
    bus.data_in = 1'b0;
    bus.data_valid = 1'b0;
    bus.inject_err = 1'b0;
    repeat (2) @(negedge clock);
    reset = 1'b1;
  endtask

  // One slot, starting just after a negedge. While phase is 0 the inputs are
  // driven with junk to show they are ignored.
  task automatic run_slot(input string tag, input bit d, input bit v, input bit inj,
                          output logic o1, output logic o2, output logic ef2,
                          output logic id, output logic [3:0] cnt);
    bus.data_in = d;
    bus.data_valid = v;
    bus.inject_err = inj;
    #1 check({tag, ".ready0"}, bus.data_ready, 1'b1);
    @(posedge clock);
    @(negedge clock);
    o1 = out;
    id = idle;
    check({tag, ".phase1"}, out_phase, 1'b0);
    check({tag, ".ready1"}, bus.data_ready, 1'b0);
    check({tag, ".err1"}, err_flag, 1'b0);
    bus.data_in = 1'b1;
    bus.data_valid = 1'b1;
    bus.inject_err = 1'b1;
    @(posedge clock);
    @(negedge clock);
    o2 = out;
    ef2 = err_flag;
    cnt = sym_count;
    check({tag, ".phase2"}, out_phase, 1'b1);
  endtask

  vec_t vecs[$];

  initial begin
    logic       o1, o2, ef2, id;
    logic [3:0] cnt;
    logic [16:0] pattern;
    bit         mp1, mp2, mc1, mc2, lp1, lp2;

    // rst d v inj e1 e2 idle err cnt
    vecs.push_back('{1, 1, 1, 0, 1, 1, 0, 0, 4'd1});
    vecs.push_back('{0, 0, 1, 0, 1, 0, 0, 0, 4'd2});
    vecs.push_back('{0, 1, 1, 0, 1, 0, 0, 0, 4'd3});
    vecs.push_back('{0, 1, 1, 0, 1, 0, 0, 0, 4'd4});
    vecs.push_back('{1, 0, 0, 0, 0, 0, 1, 0, 4'd0});
    vecs.push_back('{0, 0, 0, 0, 0, 0, 1, 0, 4'd0});
    vecs.push_back('{0, 0, 0, 0, 0, 0, 1, 0, 4'd0});
    vecs.push_back('{0, 0, 0, 0, 0, 0, 1, 0, 4'd0});
    // 1 then 0, then an idle slot: d=0, p1=1, p2=0 gives c1=0, c2=1
    vecs.push_back('{1, 1, 1, 0, 1, 1, 0, 0, 4'd1});
    vecs.push_back('{0, 0, 1, 0, 1, 0, 0, 0, 4'd2});
    vecs.push_back('{0, 0, 0, 0, 0, 1, 1, 0, 4'd2});
    // injection on first symbol; second symbol uses uninjected p2=1
    vecs.push_back('{1, 1, 1, 1, 1, 0, 0, 1, 4'd1});
    vecs.push_back('{0, 1, 1, 0, 0, 1, 0, 0, 4'd2});
    // injection on an idle symbol
    vecs.push_back('{1, 0, 0, 1, 0, 1, 1, 1, 4'd0});

    reset = 1'b0;
    bus.data_in = 1'b1;
    bus.data_valid = 1'b1;
    bus.inject_err = 1'b1;
    repeat (3) @(negedge clock);
    check("rst.out", out, 1'b0);
    check("rst.idle", idle, 1'b1);
    check("rst.err", err_flag, 1'b0);
    check("rst.cnt", sym_count, 4'd0);
    check("rst.ready", bus.data_ready, 1'b1);
    check("rst.phase", out_phase, 1'b1);

    foreach (vecs[i]) begin
      string tag;
      tag = $sformatf("v%0d", i);
      if (vecs[i].rst) do_reset();
      run_slot(tag, vecs[i].d, vecs[i].v, vecs[i].inj, o1, o2, ef2, id, cnt);
      check({tag, ".c1"}, o1, vecs[i].e1);
      check({tag, ".c2"}, o2, vecs[i].e2);
      check({tag, ".idle"}, id, vecs[i].eidle);
      check({tag, ".err2"}, ef2, vecs[i].eerr);
      check({tag, ".cnt"}, cnt, vecs[i].ecnt);
    end

    // Reset asserted during the c1 cycle of a symbol.
    do_reset();
    run_slot("mid_a", 1'b1, 1'b1, 1'b0, o1, o2, ef2, id, cnt);
    bus.data_in = 1'b1;
    bus.data_valid = 1'b1;
    bus.inject_err = 1'b0;
    @(posedge clock);
    @(negedge clock);
    check("mid.pre_c1", out, 1'b0);
    check("mid.pre_cnt", sym_count, 4'd2);
    #2 reset = 1'b0;
    #1;
    check("mid.out", out, 1'b0);
    check("mid.phase", out_phase, 1'b1);
    check("mid.cnt", sym_count, 4'd0);
    check("mid.ready", bus.data_ready, 1'b1);
    @(negedge clock);
    reset = 1'b1;
    run_slot("mid_b", 1'b1, 1'b1, 1'b0, o1, o2, ef2, id, cnt);
    check("mid.c1", o1, 1'b1);
    check("mid.c2", o2, 1'b1);
    check("mid.cnt1", cnt, 4'd1);

    // 17 data symbols through a 4-bit counter, checked against the
    // encoding rule and decoded back with the parity check.
    do_reset();
    pattern = 17'b1_0110_0101_1100_1011;
    mp1 = 0; mp2 = 0; lp1 = 0; lp2 = 0;
    for (int i = 0; i < 17; i++) begin
      string tag;
      tag = $sformatf("w%0d", i);
      run_slot(tag, pattern[i], 1'b1, 1'b0, o1, o2, ef2, id, cnt);
      mc1 = pattern[i] ^ mp2;
      mc2 = mc1 ^ mp1;
      mp1 = mc1;
      mp2 = mc2;
      check({tag, ".c1"}, o1, mc1);
      check({tag, ".c2"}, o2, mc2);
      check({tag, ".parity"}, o1 ^ o2, lp1);
      check({tag, ".decode"}, o1 ^ lp2, pattern[i]);
      lp1 = o1;
      lp2 = o2;
      if (i == 14) check("wrap.15", cnt, 4'd15);
      if (i == 15) check("wrap.0", cnt, 4'd0);
      if (i == 16) check("wrap.1", cnt, 4'd1);
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
